jpeg_byte_stuffer: RTL

Sits directly downstream of jpeg_pipeline and consumes its packed entropy-coded output, which arrives as a 16-bit word with a 0–2 byte valid count. It serialises that output to a byte stream and inserts a 0x00 after every 0xFF data byte, as JPEG byte stuffing requires. When the pipeline signals that its flush is complete, the block appends the EOI marker (0xFF 0xD9) without stuffing. An internal byte FIFO decouples the bursty upstream from a byte-wide downstream sink.

---
 rtl/jpeg_byte_stuffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/jpeg_byte_stuffer.sv
// JPEG byte stuffer: serialises 0-2 byte entropy-coded words into a byte FIFO,
// inserting 0x00 after each 0xFF data byte and optionally appending an EOI marker.
module jpeg_byte_stuffer #(
    parameter int DEPTH    = 16,
    parameter bit EMIT_EOI = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_bits,
    input  logic [1:0]  in_valid,
    input  logic        ena_in,
    output logic        rdy_out,
    input  logic        done_flush_in,
    output logic [7:0]  out_byte,
    output logic        ena_out,
    input  logic        rdy_in,
    output logic        done_stream
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        STREAM = 2'd0,
        EOI_FF = 2'd1,
        EOI_D9 = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            done_q, done_d;
    logic [3:0][7:0] wr_byte_s;
    logic [2:0]      wr_cnt_s;
    logic            pop_s, rdy_s, accept_s, space1_s;

    // A full 0xFFFF word expands to four bytes, so four free slots are required.
    assign rdy_s    = (state_q == STREAM) && ((DEPTH_C - count_q) >= CW'(4));
    assign accept_s = ena_in && rdy_s;
    assign ena_out  = (count_q != CW'(0));
    assign pop_s    = ena_out && rdy_in;
    assign space1_s = (count_q != DEPTH_C) || pop_s;
    assign rdy_out  = rst_n && rdy_s;
    assign out_byte = ena_out ? mem_q[rptr_q] : 8'h00;
    assign done_stream = done_q;

    // Next-state and write-slot selection; stuffing zeros come from the 0x00 defaults.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        wr_cnt_s  = 3'd0;
        wr_byte_s = '0;
        case (state_q)
            STREAM: begin
                if (accept_s) begin
                    if (in_valid != 2'd0) begin
                        wr_byte_s[0] = in_bits[15:8];
                        wr_cnt_s     = (in_bits[15:8] == 8'hFF) ? 3'd2 : 3'd1;
                    end else begin
                        wr_cnt_s = 3'd0;
                    end
                    if (in_valid[1]) begin
                        wr_byte_s[wr_cnt_s[1:0]] = in_bits[7:0];
                        wr_cnt_s = wr_cnt_s + ((in_bits[7:0] == 8'hFF) ? 3'd2 : 3'd1);
                    end else begin
                        wr_cnt_s = wr_cnt_s;
                    end
                end else begin
                    wr_cnt_s = 3'd0;
                end
                if (done_flush_in) begin
                    state_d = EMIT_EOI ? EOI_FF : DRAIN;
                end else begin
                    state_d = STREAM;
                end
            end
            EOI_FF: begin
                if (space1_s) begin
                    wr_byte_s[0] = 8'hFF;
                    wr_cnt_s     = 3'd1;
                    state_d      = EOI_D9;
                end else begin
                    state_d = EOI_FF;
                end
            end
            EOI_D9: begin
                if (space1_s) begin
                    wr_byte_s[0] = 8'hD9;
                    wr_cnt_s     = 3'd1;
                    state_d      = DRAIN;
                end else begin
                    state_d = EOI_D9;
                end
            end
            DRAIN: begin
                if ((count_q == CW'(0)) || ((count_q == CW'(1)) && pop_s)) begin
                    done_d  = 1'b1;
                    state_d = STREAM;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = STREAM;
            end
        endcase
    end

    // Pointer and occupancy arithmetic.
    always_comb begin
        wptr_d  = wptr_q + AW'(wr_cnt_s);
        rptr_d  = rptr_q + AW'(pop_s);
        count_d = count_q + CW'(wr_cnt_s) - CW'(pop_s);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STREAM;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Byte storage: up to four consecutive slots written per cycle.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < wr_cnt_s) begin
                mem_q[wptr_q + AW'(k)] <= wr_byte_s[k];
            end
        end
    end
endmodule
